// File: rtl/pong_ps2_pkg.sv
// Shared PS/2 Set-2 definitions for the Pong keyboard front end:
// scan codes, the ignored-byte list and the prefix-state enum.
package pong_ps2_pkg;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_UP    = 8'h75;  // only with the E0 prefix
  localparam logic [7:0] SC_DOWN  = 8'h72;  // only with the E0 prefix
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;

  // Keyboard housekeeping replies, pause-key prefix and error bytes.
  localparam int N_IGNORED = 8;
  localparam logic [N_IGNORED-1:0][7:0] IGNORED_BYTES = {
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF, 8'hE1
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_t;

  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_IGNORED; i++) begin
      if (b == IGNORED_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_paddle_keys_if.sv
// Byte-in / key-state-out bundle between the PS/2 receiver side and the decoder.
// Handshake: ps2_byte_en is a one-cycle strobe qualifying ps2_byte; there is no
// ready, every strobe is consumed, and strobes may arrive on consecutive cycles.
interface ps2_paddle_keys_if;
  import pong_ps2_pkg::*;

  logic [7:0]    ps2_byte;
  logic          ps2_byte_en;
  logic          p1_up;
  logic          p1_down;
  logic          p2_up;
  logic          p2_down;
  logic          start_pulse;
  logic          pause_pulse;
  logic [7:0]    last_code;
  logic          last_ext;
  logic          last_break;
  prefix_state_t dbg_state;

  modport master (
    output ps2_byte, ps2_byte_en,
    input  p1_up, p1_down, p2_up, p2_down, start_pulse, pause_pulse,
    input  last_code, last_ext, last_break, dbg_state
  );

  modport slave (
    input  ps2_byte, ps2_byte_en,
    output p1_up, p1_down, p2_up, p2_down, start_pulse, pause_pulse,
    output last_code, last_ext, last_break, dbg_state
  );

endinterface

// File: rtl/ps2_prefix_fsm.sv
// Tracks E0/F0 prefixes and emits a combinational one-cycle code_valid with the
// final byte and its ext/brk flags; a stale prefix is dropped after a timeout.
module ps2_prefix_fsm
  import pong_ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_en,
  output logic          o_code_valid,
  output logic [7:0]    o_code,
  output logic          o_ext,
  output logic          o_brk,
  output prefix_state_t o_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  prefix_state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_accept     = i_byte_en && !is_ignored(i_byte);
    w_next       = r_state;
    o_code_valid = 1'b0;
    o_code       = i_byte;
    o_ext        = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    o_brk        = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);

    if (w_accept) begin
      if (i_byte == SC_E0) begin
        if (r_state == ST_IDLE)     w_next = ST_EXT;
        else if (r_state == ST_BRK) w_next = ST_EXT_BRK;
      end else if (i_byte == SC_F0) begin
        if (r_state == ST_IDLE)     w_next = ST_BRK;
        else if (r_state == ST_EXT) w_next = ST_EXT_BRK;
      end else begin
        o_code_valid = 1'b1;
        w_next       = ST_IDLE;
      end
    end else if (r_state != ST_IDLE && r_cnt == TO_MAX) begin
      // A byte in the expiry cycle still decodes in the prefix state.
      w_next = ST_IDLE;
    end

    if (w_accept || w_next == ST_IDLE) w_cnt_next = '0;
    else                               w_cnt_next = r_cnt + CW'(1);
  end

  assign o_state = r_state;

endmodule

// File: rtl/ps2_paddle_keys.sv
// PS/2 Set-2 decoder for Pong: paddle held bits, start/pause make-edge pulses
// and the last complete scan code for the HEX debug display.
module ps2_paddle_keys
  import pong_ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic            CLOCK_50,
  input  logic            resetn,
  ps2_paddle_keys_if.slave bus
);

  logic          w_valid, w_ext, w_brk;
  logic [7:0]    w_code;
  prefix_state_t w_state;

  ps2_prefix_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_prefix (
    .clk          (CLOCK_50),
    .rst_n        (resetn),
    .i_byte       (bus.ps2_byte),
    .i_byte_en    (bus.ps2_byte_en),
    .o_code_valid (w_valid),
    .o_code       (w_code),
    .o_ext        (w_ext),
    .o_brk        (w_brk),
    .o_state      (w_state)
  );

  logic w_hit_w, w_hit_s, w_hit_up, w_hit_down, w_hit_space, w_hit_esc;
  assign w_hit_w     = w_valid && !w_ext && (w_code == SC_W);
  assign w_hit_s     = w_valid && !w_ext && (w_code == SC_S);
  assign w_hit_up    = w_valid &&  w_ext && (w_code == SC_UP);
  assign w_hit_down  = w_valid &&  w_ext && (w_code == SC_DOWN);
  assign w_hit_space = w_valid && !w_ext && (w_code == SC_SPACE);
  assign w_hit_esc   = w_valid && !w_ext && (w_code == SC_ESC);

  logic       r_p1_up, r_p1_down, r_p2_up, r_p2_down, r_space, r_esc;
  logic       r_start, r_pause, r_last_ext, r_last_break;
  logic [7:0] r_last_code;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_p1_up      <= 1'b0;
      r_p1_down    <= 1'b0;
      r_p2_up      <= 1'b0;
      r_p2_down    <= 1'b0;
      r_space      <= 1'b0;
      r_esc        <= 1'b0;
      r_start      <= 1'b0;
      r_pause      <= 1'b0;
      r_last_code  <= 8'h00;
      r_last_ext   <= 1'b0;
      r_last_break <= 1'b0;
    end else begin
      // Space/Esc held bits exist only so typematic repeats don't re-pulse.
      r_start <= w_hit_space && !w_brk && !r_space;
      r_pause <= w_hit_esc   && !w_brk && !r_esc;
      if (w_valid) begin
        r_last_code  <= w_code;
        r_last_ext   <= w_ext;
        r_last_break <= w_brk;
      end
      if (w_hit_w)     r_p1_up   <= !w_brk;
      if (w_hit_s)     r_p1_down <= !w_brk;
      if (w_hit_up)    r_p2_up   <= !w_brk;
      if (w_hit_down)  r_p2_down <= !w_brk;
      if (w_hit_space) r_space   <= !w_brk;
      if (w_hit_esc)   r_esc     <= !w_brk;
    end
  end

  assign bus.p1_up       = r_p1_up;
  assign bus.p1_down     = r_p1_down;
  assign bus.p2_up       = r_p2_up;
  assign bus.p2_down     = r_p2_down;
  assign bus.start_pulse = r_start;
  assign bus.pause_pulse = r_pause;
  assign bus.last_code   = r_last_code;
  assign bus.last_ext    = r_last_ext;
  assign bus.last_break  = r_last_break;
  assign bus.dbg_state   = w_state;

endmodule

// File: doc/ps2_paddle_keys.md
# ps2_paddle_keys

Decodes the PS/2 Set-2 byte stream from `PS2_Controller` (`received_data` / `received_data_en`) into paddle and control signals for the Pong game logic. It sits directly downstream of the PS/2 receiver. It tracks the `E0` (extended) and `F0` (break) prefixes and keeps a held/released bit for each game key. Start and pause come out as one-cycle pulses, and the most recent complete scan code is held for the HEX debug display.

## Interface
- `TIMEOUT_CYCLES`, default 2_500_000 (50 ms at 50 MHz): idle cycles after a prefix byte before the prefix state is abandoned.
- `CLOCK_50`  in  1  system clock, all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset (driven from `KEY[0]`).
- `ps2_byte`  in  8  received byte (`received_data`).
- `ps2_byte_en`  in  1  one-cycle strobe, `ps2_byte` valid (`received_data_en`).
- `p1_up`  out  1  W (`1D`) held.
- `p1_down`  out  1  S (`1B`) held.
- `p2_up`  out  1  Up arrow (`E0 75`) held.
- `p2_down`  out  1  Down arrow (`E0 72`) held.
- `start_pulse`  out  1  one cycle on a Space (`29`) make edge.
- `pause_pulse`  out  1  one cycle on an Esc (`76`) make edge.
- `last_code`  out  8  final byte of the last complete make/break sequence.
- `last_ext`  out  1  that sequence was extended.
- `last_break`  out  1  that sequence was a break.

## Operation
- **Reset values:** all outputs are 0 and the FSM is in IDLE. Reset is asynchronous and valid at any point, including mid-sequence.
- **FSM states:** IDLE, EXT (seen `E0`), BRK (seen `F0`), EXT_BRK (seen `E0 F0`). Transitions happen only on `ps2_byte_en`.
  - IDLE: `E0` goes to EXT; `F0` goes to BRK; any other byte is a make code and the FSM stays in IDLE.
  - EXT: `F0` goes to EXT_BRK; `E0` stays in EXT; any other byte is an extended make and the FSM returns to IDLE.
  - BRK: any byte other than `E0`/`F0` is a break and the FSM returns to IDLE. `F0` stays in BRK. `E0` goes to EXT_BRK (tolerates the non-standard `F0 E0` order).
  - EXT_BRK: any byte other than `E0`/`F0` is an extended break and the FSM returns to IDLE. Prefix bytes keep the state.
- **Ignored bytes:** `00`, `AA`, `EE`, `FA`, `FC`, `FE`, `FF` and `E1` are dropped in every state. The FSM state, key bits and `last_*` outputs are unchanged.
- **Completed sequences:** each complete make/break updates `last_code`, `last_ext` and `last_break`, including unmapped keys. Held bits change only for the six mapped (code, ext) pairs.
- **Extension matching:** the extension must match exactly. A plain `75` (keypad 8) does not affect `p2_up`.
- **Key bits:** a make sets the bit and a break clears it. Typematic repeats (a make while already held) leave the bit at 1.
- **Pulses:** `start_pulse` / `pause_pulse` fire only when the held bit goes 0→1. Typematic repeats produce no further pulse. Space and Esc keep internal held bits so the edge can be detected.
- **Opposite keys:** pressing both directions of one paddle drives both outputs high. Resolution is the game logic's job.
- **Prefix timeout:** a counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on every accepted byte and counts only in EXT, BRK and EXT_BRK. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE with no key change. In IDLE the counter holds at 0.

## Timing
- A byte strobed in cycle N updates the FSM, key outputs and `last_*` at the edge ending cycle N. They are visible in N+1.
- Latency from the final byte to the output is exactly 1 cycle.
- Pulses are high for exactly cycle N+1.
- There is no backpressure. Every `ps2_byte_en` is consumed, and back-to-back strobes on consecutive cycles must decode correctly.
- **Timeout boundary:** a byte arriving in the same cycle the counter reaches `TIMEOUT_CYCLES` is decoded in the prefix state (the byte wins). The timeout takes effect only if no strobe arrives that cycle.

## Structure
- Shared package `pong_ps2_pkg`, containing:
  - scan-code constants `SC_W`, `SC_S`, `SC_UP`, `SC_DOWN`, `SC_SPACE`, `SC_ESC`, `SC_E0`, `SC_F0`;
  - the ignored-byte list;
  - the prefix-state enum.
- One natural sub-module, `ps2_prefix_fsm`. It takes the FSM and timeout and emits a one-cycle `code_valid` together with `code`, `ext` and `brk`. The key map, held bits and pulses stay in the top level.

## Test plan
- **Plain make/break:** send `1D`, then `F0 1D` 40 cycles later → `p1_up` = 1 from the cycle after `1D`, back to 0 the cycle after the final `1D`; `last_break` = 1, `last_code` = `1D`.
- **Extended keys:** send `E0 75`, then `E0 72`, then `E0 F0 75` → `p2_up` = 1 then 0, `p2_down` stays 1. A plain `75` leaves `p2_up` = 0.
- **Typematic:** send `29` three times, then `F0 29` → exactly one `start_pulse`, one cycle wide, after the first `29`. A second press after release gives a second pulse.
- **Timeout:** with `TIMEOUT_CYCLES` = 100, send `F0`, wait 101 cycles, send `1B` → treated as a make, `p1_down` = 1. With a wait of 99 cycles the byte is a break and `p1_down` stays 0.
- **Noise and back-to-back:** send `FA AA E0 F0 72` on consecutive cycles with `p2_down` previously 1 → `p2_down` = 0, `last_code` = `72`, `last_ext` = 1. `FA` and `AA` change nothing.
- **Reset mid-sequence:** pulse `resetn` low after `E0`, then send `75` → all outputs cleared, and `75` decodes as a non-extended make (`p2_up` stays 0, `last_ext` = 0).
